rom_read_arbiter: RTL

//  Shares the single puzzle-input ROM (8-bit data, sync read) between N_REQ read clients,
//  e.g. the line parser and the node-name lookup engine in day11_core.

---
 rtl/day11_pkg.sv | 24 ++
 rtl/rom_read_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/rom_read_arbiter.sv | 78 +++++++
 4 files changed

// File: rtl/day11_pkg.sv
// Shared constants and width helpers for the puzzle-input ROM path.
// Imported by the arbiter, its interface and the testbench.
package day11_pkg;

  localparam int ROM_DATA_W = 8;

  function automatic int addr_w(input int n);
    return n + 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Client-side request/response bundle of the ROM read arbiter.
// master = read client side, slave = arbiter side.
interface rom_read_arbiter_if
  import day11_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 17
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rsp_valid;
  logic [ROM_DATA_W-1:0]   rsp_data;
  logic                    rsp_eof;

  modport master (
    output req, req_addr,
    input  gnt, rsp_valid, rsp_data, rsp_eof
  );

  modport slave (
    input  req, req_addr,
    output gnt, rsp_valid, rsp_data, rsp_eof
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic found;

  function automatic logic [IDX_W-1:0] wrap(
    input logic [IDX_W-1:0] p,
    input int               k
  );
    int j;
    j = int'(p) + k;
    if (j >= N_REQ) j = j - N_REQ;
    return j[IDX_W-1:0];
  endfunction

  // scan from the pointer, take the first live request
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[wrap(ptr_i, k)]) begin
        found     = 1'b1;
        gnt_idx_o = wrap(ptr_i, k);
      end
    end
    gnt_o = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one sync-read ROM among N_REQ clients: round-robin grant,
// one read per cycle, tagged responses routed back in issue order.
module rom_read_arbiter
  import day11_pkg::*;
#(
  parameter  int N_ADDR_BITS = 16,
  parameter  int N_REQ       = 2,
  parameter  int ROM_LATENCY = 1,
  localparam int ADDR_W      = addr_w(N_ADDR_BITS),
  localparam int IDX_W       = idx_w(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_read_arbiter_if.slave     cif,
  output logic                  busy,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [ROM_DATA_W-1:0] rom_data,
  input  logic                  rom_valid
);

  logic [N_REQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   any_gnt;
  logic [ADDR_W-1:0]      gnt_addr;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]      last_addr_q;
  logic [ROM_LATENCY-1:0] vld_q;
  logic [IDX_W-1:0]       idx_q [ROM_LATENCY];
  logic                   rsp_vld;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i     (cif.req),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (gnt_idx)
  );

  // no grant may escape while held in reset
  assign cif.gnt  = rst ? '0 : arb_gnt;
  assign any_gnt  = |cif.gnt;
  assign gnt_addr = cif.req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign rom_addr = any_gnt ? gnt_addr : last_addr_q;

  assign ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;

  // response side: last tag stage meets ROM output this cycle
  assign rsp_vld       = vld_q[ROM_LATENCY-1];
  assign cif.rsp_valid = rsp_vld ?
    ({{(N_REQ-1){1'b0}}, 1'b1} << idx_q[ROM_LATENCY-1]) : '0;
  assign cif.rsp_data  = rsp_vld ? rom_data : '0;
  assign cif.rsp_eof   = rsp_vld & ~rom_valid;
  assign busy          = |vld_q;

  // pointer, held address and tag pipeline advance every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      last_addr_q <= '0;
      vld_q       <= '0;
      for (int s = 0; s < ROM_LATENCY; s++) idx_q[s] <= '0;
    end else begin
      if (any_gnt) begin
        ptr_q       <= ptr_d;
        last_addr_q <= gnt_addr;
      end
      vld_q[0] <= any_gnt;
      idx_q[0] <= gnt_idx;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

endmodule
